fetch_unit: RTL

- Instruction fetch stage that directly feeds the immediate generator.
- Holds the program counter and runs a single-outstanding request/ack transaction to instruction memory.
- Latches the returned 16-bit instruction word and presents it split into opcode[15:12] and the 12-bit immediate field[11:0].
- The immediate field drives imm_in of the downstream sign-extender. Supports stall from decode and PC redirect from branch/jump resolution.

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit_pc_reg.sv | 90 +++++++++
 rtl/fetch_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch stage. Decode and the
// immediate generator reuse the field positions and state encoding.
//   - word / field widths and opcode / immediate slice positions
//   - fetch FSM state encoding (IDLE, REQ, HOLD)
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

   localparam int FETCH_DATA_W  = 16;
   localparam int FETCH_IMM_W   = 12;
   localparam int FETCH_OP_W    = 4;

   // Field slice positions inside an instruction word
   localparam int FETCH_OP_MSB  = FETCH_DATA_W - 1;
   localparam int FETCH_OP_LSB  = FETCH_DATA_W - FETCH_OP_W;
   localparam int FETCH_IMM_MSB = FETCH_IMM_W - 1;
   localparam int FETCH_IMM_LSB = 0;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t ST_IDLE = 2'd0;
   localparam fetch_state_t ST_REQ  = 2'd1;
   localparam fetch_state_t ST_HOLD = 2'd2;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction memory request/ack bus, single outstanding transaction.
//   req   : fetch request, held until ack (driven by the fetch stage)
//   addr  : fetch byte address, stable while req=1
//   ack   : memory returns rdata this cycle
//   rdata : instruction word
// master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int DATA_W = FETCH_DATA_W
) ();

   logic              req;
   logic [DATA_W-1:0] addr;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req,
      output addr,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output ack,
      output rdata
   );

endinterface : fetch_unit_if

// File: rtl/fetch_unit_pc_reg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pc_reg
// Program counter for the fetch stage. Holds pc, the deferred redirect
// target pend_pc and the kill flag that marks the in-flight fetch as stale.
//   clk, rst     : clock, synchronous active-high reset
//   redirect     : branch/jump redirect this cycle
//   redirect_pc  : redirect byte address (bit0 is dropped)
//   defer        : a fetch is in flight with no ack this cycle
//   resolve      : the ack of a killed fetch arrives this cycle
//   advance      : step to the next sequential instruction
//   pc           : current fetch / held-instruction address
//   pc_plus2     : pc + 2, wrapping
//   kill         : in-flight fetch must be discarded
// ---------------------------------------------------------------------------
module fetch_unit_pc_reg
   import fetch_unit_pkg::*;
#(
   parameter int                DATA_W   = FETCH_DATA_W,
   parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [DATA_W-1:0] redirect_pc,
   input  logic              defer,
   input  logic              resolve,
   input  logic              advance,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] pc_plus2,
   output logic              kill
);

   localparam logic [DATA_W-1:0] PC_STEP    = {{(DATA_W-2){1'b0}}, 2'b10};
   localparam logic [DATA_W-1:0] ALIGN_MASK = ~{{(DATA_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] pc_r;
   logic [DATA_W-1:0] pc_plus2_r;
   logic [DATA_W-1:0] pend_pc_r;
   logic              kill_r;

   logic [DATA_W-1:0] target_s;
   logic [DATA_W-1:0] pc_nxt_s;
   logic [DATA_W-1:0] pend_nxt_s;
   logic              kill_nxt_s;

   // Instructions are halfword aligned; a misaligned target is silently fixed.
   assign target_s = redirect_pc & ALIGN_MASK;

   // Next pc / pend_pc / kill selection, most urgent event first
   always_comb begin
      pc_nxt_s   = pc_r;
      pend_nxt_s = pend_pc_r;
      kill_nxt_s = kill_r;
      if (resolve) begin
         // Stale fetch completes: a redirect in the same cycle is the newest target.
         pc_nxt_s   = redirect ? target_s : pend_pc_r;
         kill_nxt_s = 1'b0;
      end else if (redirect && defer) begin
         // Address must stay stable until ack; park the target, last one wins.
         pend_nxt_s = target_s;
         kill_nxt_s = 1'b1;
      end else if (redirect) begin
         pc_nxt_s = target_s;
      end else if (advance) begin
         pc_nxt_s = pc_r + PC_STEP;
      end else begin
         pc_nxt_s = pc_r;
      end
   end

   // PC state registers; pc_plus2 is registered alongside pc so it is glitch-free
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r       <= RESET_PC;
         pc_plus2_r <= RESET_PC + PC_STEP;
         pend_pc_r  <= RESET_PC;
         kill_r     <= 1'b0;
      end else begin
         pc_r       <= pc_nxt_s;
         pc_plus2_r <= pc_nxt_s + PC_STEP;
         pend_pc_r  <= pend_nxt_s;
         kill_r     <= kill_nxt_s;
      end
   end

   assign pc       = pc_r;
   assign pc_plus2 = pc_plus2_r;
   assign kill     = kill_r;

endmodule : fetch_unit_pc_reg

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage feeding decode and the immediate generator.
// Runs one outstanding request/ack transaction at a time, latches the
// returned word and presents it split into opcode and immediate fields.
//   CLK, RST        : clock, synchronous active-high reset
//   stall_in        : decode not ready, hold current instruction
//   redirect_valid  : load redirect_pc (branch/jump taken)
//   redirect_pc     : redirect target byte address
//   imem            : instruction memory bus (master side)
//   instr_valid     : instr_out / opcode_out / imm_field_out valid
//   instr_out       : latched instruction
//   opcode_out      : instr_out[15:12]
//   imm_field_out   : instr_out[11:0], drives the sign-extender imm_in
//   pc_out          : address of the held instruction
//   pc_plus2_out    : pc_out + 2, wrapping
// ---------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                DATA_W   = FETCH_DATA_W,
   parameter int                IMM_W    = FETCH_IMM_W,
   parameter int                OP_W     = FETCH_OP_W,
   parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              stall_in,
   input  logic              redirect_valid,
   input  logic [DATA_W-1:0] redirect_pc,
   fetch_unit_if.master      imem,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_out,
   output logic [OP_W-1:0]   opcode_out,
   output logic [IMM_W-1:0]  imm_field_out,
   output logic [DATA_W-1:0] pc_out,
   output logic [DATA_W-1:0] pc_plus2_out
);

   fetch_state_t      state_r;
   fetch_state_t      state_nxt_s;
   logic              req_r;
   logic              req_nxt_s;
   logic              valid_r;
   logic              valid_nxt_s;
   logic [DATA_W-1:0] instr_r;
   logic [DATA_W-1:0] instr_nxt_s;

   logic              flight_s;
   logic              ack_s;
   logic              defer_s;
   logic              resolve_s;
   logic              advance_s;
   logic              kill_s;
   logic [DATA_W-1:0] pc_s;
   logic [DATA_W-1:0] pc_plus2_s;

   // An ack only counts while our request is actually on the bus.
   assign flight_s  = (state_r == ST_REQ) && req_r;
   assign ack_s     = flight_s && imem.ack;
   assign defer_s   = flight_s && !imem.ack;
   assign resolve_s = ack_s && kill_s;
   assign advance_s = (state_r == ST_HOLD) && !stall_in;

   fetch_unit_pc_reg #(
      .DATA_W   (DATA_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk         (CLK),
      .rst         (RST),
      .redirect    (redirect_valid),
      .redirect_pc (redirect_pc),
      .defer       (defer_s),
      .resolve     (resolve_s),
      .advance     (advance_s),
      .pc          (pc_s),
      .pc_plus2    (pc_plus2_s),
      .kill        (kill_s)
   );

   // Fetch FSM next-state, request and instruction-latch decisions
   always_comb begin
      state_nxt_s = state_r;
      req_nxt_s   = req_r;
      valid_nxt_s = valid_r;
      instr_nxt_s = instr_r;
      case (state_r)
         ST_IDLE: begin
            state_nxt_s = ST_REQ;
            req_nxt_s   = 1'b1;
            valid_nxt_s = 1'b0;
         end
         ST_REQ: begin
            if (!req_r) begin
               // Bus was released for a cycle after a killed fetch; reissue.
               req_nxt_s = 1'b1;
            end else if (imem.ack) begin
               req_nxt_s = 1'b0;
               if (kill_s) begin
                  // Stale data dropped; pc reloads from pend_pc, request again.
                  state_nxt_s = ST_REQ;
               end else if (redirect_valid) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  instr_nxt_s = imem.rdata;
                  valid_nxt_s = 1'b1;
                  state_nxt_s = ST_HOLD;
               end
            end else begin
               req_nxt_s = 1'b1;
            end
         end
         ST_HOLD: begin
            // Redirect takes precedence over a decode stall.
            if (redirect_valid || !stall_in) begin
               valid_nxt_s = 1'b0;
               req_nxt_s   = 1'b1;
               state_nxt_s = ST_REQ;
            end else begin
               valid_nxt_s = 1'b1;
               req_nxt_s   = 1'b0;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            req_nxt_s   = 1'b0;
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // FSM, bus request and instruction latch registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_IDLE;
         req_r   <= 1'b0;
         valid_r <= 1'b0;
         instr_r <= {DATA_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         req_r   <= req_nxt_s;
         valid_r <= valid_nxt_s;
         instr_r <= instr_nxt_s;
      end
   end

   assign imem.req      = req_r;
   assign imem.addr     = pc_s;
   assign instr_valid   = valid_r;
   assign instr_out     = instr_r;
   assign opcode_out    = instr_r[DATA_W-1 -: OP_W];
   assign imm_field_out = instr_r[IMM_W-1:0];
   assign pc_out        = pc_s;
   assign pc_plus2_out  = pc_plus2_s;

endmodule : fetch_unit
